// File: rtl/axis_frame_len_adjust.sv
// -----------------------------------------------------------------------------
// axis_frame_len_adjust
//
// Frame-length conditioning stage for an AXI4-Stream. Sits downstream of the
// stream FIFO and forwards frames with a runtime length floor and ceiling:
//   - frames shorter than length_min are padded with PAD_VALUE fill beats;
//   - frames longer than length_max are cut at length_max beats and the rest
//     of their input beats are consumed and discarded.
// One registered output stage (one cycle latency, full throughput), plus a
// one-cycle status pulse per completed frame.
//
// Build option (macro):
//   AXIS_FRAME_LEN_ADJUST_TRUNC_MARK_EN
//     defined   : the truncating output beat has every tuser bit set.
//     undefined : the truncating beat carries its input tuser unchanged.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   s_axis_t{data,valid,ready,last,user}   input stream
//   m_axis_t{data,valid,ready,last,user}   output stream
//   length_min                      minimum output beats (0 = no padding)
//   length_max                      maximum output beats (0 = no truncation)
//   status_valid                    one-cycle pulse per completed frame
//   status_frame_pad                frame was padded
//   status_frame_truncate           frame was truncated
//   status_frame_length             beats emitted
//   status_frame_original_length    beats consumed (saturating)
// -----------------------------------------------------------------------------
module axis_frame_len_adjust #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    USER_WIDTH = 1,
  parameter int                    LEN_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,

  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,

  input  logic [LEN_WIDTH-1:0]  length_min,
  input  logic [LEN_WIDTH-1:0]  length_max,

  output logic                  status_valid,
  output logic                  status_frame_pad,
  output logic                  status_frame_truncate,
  output logic [LEN_WIDTH-1:0]  status_frame_length,
  output logic [LEN_WIDTH-1:0]  status_frame_original_length
);

  typedef enum logic [1:0] {
    PASS = 2'd0,
    PAD  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t                state_reg;
  logic [LEN_WIDTH-1:0]  out_cnt_reg;
  logic [LEN_WIDTH-1:0]  in_cnt_reg;
  logic [LEN_WIDTH-1:0]  min_reg;
  logic [LEN_WIDTH-1:0]  max_reg;
  logic [USER_WIDTH-1:0] user_hold_reg;

  logic [DATA_WIDTH-1:0] m_data_reg;
  logic                  m_valid_reg;
  logic                  m_last_reg;
  logic [USER_WIDTH-1:0] m_user_reg;

  logic                  status_valid_reg;
  logic                  status_pad_reg;
  logic                  status_trunc_reg;
  logic [LEN_WIDTH-1:0]  status_len_reg;
  logic [LEN_WIDTH-1:0]  status_orig_reg;

  function automatic logic [LEN_WIDTH-1:0] sat_inc(input logic [LEN_WIDTH-1:0] v);
    return (&v) ? v : v + LEN_WIDTH'(1);
  endfunction

  // Output register may load when it is empty or being drained this cycle.
  logic out_ready;
  assign out_ready = m_axis_tready || !m_axis_tvalid;

  // The input counter is zero only between frames (it saturates instead of
  // wrapping), so it doubles as the "next beat starts a frame" flag.
  logic first_beat;
  assign first_beat = (in_cnt_reg == '0);

  // Limits come straight from the ports on the first beat and from the
  // held copies afterwards, so the first beat already obeys them.
  logic [LEN_WIDTH-1:0] min_raw;
  logic [LEN_WIDTH-1:0] max_eff;
  logic [LEN_WIDTH-1:0] min_eff;
  assign min_raw = first_beat ? length_min : min_reg;
  assign max_eff = first_beat ? length_max : max_reg;
  // Padding target never exceeds an active ceiling.
  assign min_eff = ((min_raw != '0) && (max_eff != '0) && (min_raw > max_eff))
                   ? max_eff : min_raw;

  logic [LEN_WIDTH-1:0] out_inc;
  logic [LEN_WIDTH-1:0] in_inc;
  assign out_inc = sat_inc(out_cnt_reg);
  assign in_inc  = sat_inc(in_cnt_reg);

  logic s_ready;
  always_comb begin
    s_ready = 1'b0;
    case (state_reg)
      PASS:    s_ready = out_ready;
      PAD:     s_ready = 1'b0;
      DROP:    s_ready = 1'b1;
      default: s_ready = 1'b0;
    endcase
  end

  // Gated by rst_n so the source sees no ready while reset is held.
  assign s_axis_tready = rst_n && s_ready;

  logic accept;
  assign accept = s_axis_tvalid && s_axis_tready;

  logic [USER_WIDTH-1:0] trunc_user;
`ifdef AXIS_FRAME_LEN_ADJUST_TRUNC_MARK_EN
  assign trunc_user = '1;
`else
  assign trunc_user = s_axis_tuser;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= PASS;
      out_cnt_reg      <= '0;
      in_cnt_reg       <= '0;
      min_reg          <= '0;
      max_reg          <= '0;
      user_hold_reg    <= '0;
      m_data_reg       <= '0;
      m_valid_reg      <= 1'b0;
      m_last_reg       <= 1'b0;
      m_user_reg       <= '0;
      status_valid_reg <= 1'b0;
      status_pad_reg   <= 1'b0;
      status_trunc_reg <= 1'b0;
      status_len_reg   <= '0;
      status_orig_reg  <= '0;
    end else begin
      status_valid_reg <= 1'b0;
      // Drained beat empties the register unless a new one is loaded below.
      if (out_ready) begin
        m_valid_reg <= 1'b0;
      end

      case (state_reg)
        PASS: begin
          if (accept) begin
            m_valid_reg <= 1'b1;
            m_data_reg  <= s_axis_tdata;
            m_user_reg  <= s_axis_tuser;
            m_last_reg  <= 1'b0;
            out_cnt_reg <= out_inc;
            in_cnt_reg  <= in_inc;
            if (first_beat) begin
              min_reg <= min_eff;
              max_reg <= max_eff;
            end
            if (s_axis_tlast) begin
              if (out_inc >= min_eff) begin
                // Long enough (or exactly max): frame ends on both sides.
                m_last_reg       <= 1'b1;
                status_valid_reg <= 1'b1;
                status_pad_reg   <= 1'b0;
                status_trunc_reg <= 1'b0;
                status_len_reg   <= out_inc;
                status_orig_reg  <= in_inc;
                out_cnt_reg      <= '0;
                in_cnt_reg       <= '0;
              end else begin
                // Short frame: the real end-of-frame tuser moves to the
                // final fill beat.
                m_user_reg    <= '0;
                user_hold_reg <= s_axis_tuser;
                state_reg     <= PAD;
              end
            end else if ((max_eff != '0) && (out_inc == max_eff)) begin
              m_last_reg <= 1'b1;
              m_user_reg <= trunc_user;
              state_reg  <= DROP;
            end
          end
        end

        PAD: begin
          if (out_ready) begin
            m_valid_reg <= 1'b1;
            m_data_reg  <= PAD_VALUE;
            m_user_reg  <= '0;
            m_last_reg  <= 1'b0;
            out_cnt_reg <= out_inc;
            if (out_inc >= min_reg) begin
              m_last_reg       <= 1'b1;
              m_user_reg       <= user_hold_reg;
              state_reg        <= PASS;
              status_valid_reg <= 1'b1;
              status_pad_reg   <= 1'b1;
              status_trunc_reg <= 1'b0;
              status_len_reg   <= out_inc;
              status_orig_reg  <= in_cnt_reg;
              out_cnt_reg      <= '0;
              in_cnt_reg       <= '0;
            end
          end
        end

        DROP: begin
          // Output side is already finished; only the input tail remains.
          if (accept) begin
            in_cnt_reg <= in_inc;
            if (s_axis_tlast) begin
              state_reg        <= PASS;
              status_valid_reg <= 1'b1;
              status_pad_reg   <= 1'b0;
              status_trunc_reg <= 1'b1;
              status_len_reg   <= out_cnt_reg;
              status_orig_reg  <= in_inc;
              out_cnt_reg      <= '0;
              in_cnt_reg       <= '0;
            end
          end
        end

        default: begin
          state_reg <= PASS;
        end
      endcase
    end
  end

  assign m_axis_tdata  = m_data_reg;
  assign m_axis_tvalid = m_valid_reg;
  assign m_axis_tlast  = m_last_reg;
  assign m_axis_tuser  = m_user_reg;

  assign status_valid                 = status_valid_reg;
  assign status_frame_pad             = status_pad_reg;
  assign status_frame_truncate        = status_trunc_reg;
  assign status_frame_length          = status_len_reg;
  assign status_frame_original_length = status_orig_reg;

endmodule

// File: tb/tb_axis_frame_len_adjust.sv
// -----------------------------------------------------------------------------
// tb_axis_frame_len_adjust
//
// Directed self-checking bench for axis_frame_len_adjust (default parameters).
// A negedge monitor records transferred beats and status pulses; each test
// task drives one scenario and compares the recording with hand-computed
// expectations.
// -----------------------------------------------------------------------------
module tb_axis_frame_len_adjust;

`ifdef AXIS_FRAME_LEN_ADJUST_TRUNC_MARK_EN
  localparam logic TRUNC_USER = 1'b1;
`else
  localparam logic TRUNC_USER = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [0:0]  s_axis_tuser;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [0:0]  m_axis_tuser;
  logic [15:0] length_min;
  logic [15:0] length_max;
  logic        status_valid;
  logic        status_frame_pad;
  logic        status_frame_truncate;
  logic [15:0] status_frame_length;
  logic [15:0] status_frame_original_length;

  axis_frame_len_adjust dut (
    .clk                          (clk),
    .rst_n                        (rst_n),
    .s_axis_tdata                 (s_axis_tdata),
    .s_axis_tvalid                (s_axis_tvalid),
    .s_axis_tready                (s_axis_tready),
    .s_axis_tlast                 (s_axis_tlast),
    .s_axis_tuser                 (s_axis_tuser),
    .m_axis_tdata                 (m_axis_tdata),
    .m_axis_tvalid                (m_axis_tvalid),
    .m_axis_tready                (m_axis_tready),
    .m_axis_tlast                 (m_axis_tlast),
    .m_axis_tuser                 (m_axis_tuser),
    .length_min                   (length_min),
    .length_max                   (length_max),
    .status_valid                 (status_valid),
    .status_frame_pad             (status_frame_pad),
    .status_frame_truncate        (status_frame_truncate),
    .status_frame_length          (status_frame_length),
    .status_frame_original_length (status_frame_original_length)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        pad;
    logic        trunc;
    logic [15:0] len;
    logic [15:0] orig;
  } status_t;

  logic [7:0] out_d[$];
  logic       out_u[$];
  logic       out_l[$];
  int         out_c[$];
  int         in_c[$];
  status_t    st_q[$];
  int         cyc = 0;
  int         ready_low = 0;
  int         stall_err = 0;
  logic       stall_prev = 1'b0;
  logic [9:0] stall_hold;

  // Output ready: fixed level, or 30% random when bp_en is set.
  logic tready_fixed = 1'b1;
  logic bp_en = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    #2;
    m_axis_tready = bp_en ? ($urandom_range(0, 9) < 3) : tready_fixed;
  end

  // All inputs change at posedge+1/+2, so the negedge sees stable values.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_axis_tvalid && m_axis_tready) begin
        out_d.push_back(m_axis_tdata);
        out_u.push_back(m_axis_tuser[0]);
        out_l.push_back(m_axis_tlast);
        out_c.push_back(cyc);
      end
      if (s_axis_tvalid && s_axis_tready) in_c.push_back(cyc);
      if (status_valid)
        st_q.push_back({status_frame_pad, status_frame_truncate,
                        status_frame_length, status_frame_original_length});
      if (!s_axis_tready) ready_low++;
      if (stall_prev && (!m_axis_tvalid ||
          {m_axis_tdata, m_axis_tuser, m_axis_tlast} !== stall_hold))
        stall_err++;
      stall_prev = m_axis_tvalid && !m_axis_tready;
      stall_hold = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic clear_mon();
    out_d.delete(); out_u.delete(); out_l.delete(); out_c.delete();
    in_c.delete(); st_q.delete();
    ready_low = 0;
    stall_err = 0;
  endtask

  task automatic send_frame(input logic [7:0] data[$], input logic last_user);
    for (int i = 0; i < data.size(); i++) begin
      int wait_n = 0;
      s_axis_tdata  = data[i];
      s_axis_tlast  = (i == data.size() - 1);
      s_axis_tuser  = (i == data.size() - 1) ? last_user : 1'b0;
      s_axis_tvalid = 1'b1;
      @(negedge clk);
      while (s_axis_tready !== 1'b1 && wait_n < 500) begin
        @(negedge clk);
        wait_n++;
      end
      if (wait_n >= 500) begin
        checks++; errors++;
        $display("FAIL send_timeout: beat %0d not accepted, got ready=%b want 1", i, s_axis_tready);
      end
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic wait_done(input int n_out, input string name);
    int n = 0;
    while ((st_q.size() < 1 || out_d.size() < n_out) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL %s_timeout: got %0d status, %0d beats; want 1 status, %0d beats",
               name, st_q.size(), out_d.size(), n_out);
    end
    repeat (3) @(negedge clk);
    if (st_q.size() > 0)
      $display("%s frame: beats=%0d status pad=%b trunc=%b len=%0d orig=%0d", name,
               out_d.size(), st_q[0].pad, st_q[0].trunc, st_q[0].len, st_q[0].orig);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0; s_axis_tuser = '0;
    length_min = '0; length_max = '0;
    repeat (4) @(negedge clk);
    checks++;
    if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser} !== 11'd0) begin
      errors++;
      $display("FAIL reset_out: got v=%b d=%h l=%b u=%b want all 0",
               m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser);
    end
    checks++;
    if (s_axis_tready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b want 0", s_axis_tready);
    end
    checks++;
    if ({status_valid, status_frame_pad, status_frame_truncate,
         status_frame_length, status_frame_original_length} !== 35'd0) begin
      errors++;
      $display("FAIL reset_status: got v=%b p=%b t=%b len=%0d orig=%0d want all 0",
               status_valid, status_frame_pad, status_frame_truncate,
               status_frame_length, status_frame_original_length);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (s_axis_tready !== 1'b1) begin
      errors++; $display("FAIL idle_ready: got %b want 1", s_axis_tready);
    end
  endtask

  task automatic test_passthrough();
    logic [7:0] fd[$];
    @(posedge clk); #1;
    length_min = 16'd0; length_max = 16'd0;
    clear_mon();
    fd = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_frame(fd, 1'b0);
    wait_done(5, "pass");
    checks++;
    if (out_d.size() !== 5) begin
      errors++; $display("FAIL pass_count: got %0d want 5", out_d.size());
    end
    for (int i = 0; i < 5 && i < out_d.size() && i < in_c.size(); i++) begin
      checks++;
      if (out_d[i] !== fd[i] || out_l[i] !== (i == 4) || out_u[i] !== 1'b0) begin
        errors++;
        $display("FAIL pass_beat[%0d]: got d=%h l=%b u=%b want d=%h l=%b u=0",
                 i, out_d[i], out_l[i], out_u[i], fd[i], (i == 4));
      end
      checks++;
      if (out_c[i] !== in_c[i] + 1) begin
        errors++;
        $display("FAIL pass_latency[%0d]: got out cycle %0d want %0d", i, out_c[i], in_c[i] + 1);
      end
    end
    checks++;
    if (st_q.size() !== 1 || st_q[0] !== {1'b0, 1'b0, 16'd5, 16'd5}) begin
      errors++;
      $display("FAIL pass_status: got n=%0d want n=1 pad=0 trunc=0 len=5 orig=5", st_q.size());
    end
  endtask

  task automatic test_padding();
    logic [7:0] fd[$];
    logic [7:0] exp_d[$];
    @(posedge clk); #1;
    length_min = 16'd8; length_max = 16'd0;
    clear_mon();
    fd    = '{8'hA1, 8'hA2, 8'hA3};
    exp_d = '{8'hA1, 8'hA2, 8'hA3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(fd, 1'b1);
    wait_done(8, "pad");
    checks++;
    if (out_d.size() !== 8) begin
      errors++; $display("FAIL pad_count: got %0d want 8", out_d.size());
    end
    for (int i = 0; i < 8 && i < out_d.size(); i++) begin
      checks++;
      if (out_d[i] !== exp_d[i] || out_l[i] !== (i == 7) || out_u[i] !== (i == 7)) begin
        errors++;
        $display("FAIL pad_beat[%0d]: got d=%h l=%b u=%b want d=%h l=%b u=%b",
                 i, out_d[i], out_l[i], out_u[i], exp_d[i], (i == 7), (i == 7));
      end
    end
    checks++;
    if (ready_low !== 5) begin
      errors++; $display("FAIL pad_ready_low: got %0d cycles want 5", ready_low);
    end
    checks++;
    if (st_q.size() !== 1 || st_q[0] !== {1'b1, 1'b0, 16'd8, 16'd3}) begin
      errors++;
      $display("FAIL pad_status: got n=%0d want n=1 pad=1 trunc=0 len=8 orig=3", st_q.size());
    end
  endtask

  task automatic test_truncation();
    logic [7:0] fd[$];
    @(posedge clk); #1;
    length_min = 16'd0; length_max = 16'd4;
    clear_mon();
    fd = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19};
    send_frame(fd, 1'b0);
    wait_done(4, "trunc");
    checks++;
    if (out_d.size() !== 4 || in_c.size() !== 10) begin
      errors++;
      $display("FAIL trunc_count: got out=%0d in=%0d want out=4 in=10", out_d.size(), in_c.size());
    end
    for (int i = 0; i < 4 && i < out_d.size(); i++) begin
      checks++;
      if (out_d[i] !== fd[i] || out_l[i] !== (i == 3) ||
          out_u[i] !== ((i == 3) ? TRUNC_USER : 1'b0)) begin
        errors++;
        $display("FAIL trunc_beat[%0d]: got d=%h l=%b u=%b want d=%h l=%b u=%b", i,
                 out_d[i], out_l[i], out_u[i], fd[i], (i == 3), (i == 3) ? TRUNC_USER : 1'b0);
      end
    end
    checks++;
    if (st_q.size() !== 1 || st_q[0] !== {1'b0, 1'b1, 16'd4, 16'd10}) begin
      errors++;
      $display("FAIL trunc_status: got n=%0d want n=1 pad=0 trunc=1 len=4 orig=10", st_q.size());
    end
  endtask

  task automatic test_boundaries();
    logic [7:0] fd[$];
    logic [7:0] exp_d[$];
    // Exactly min beats: no padding.
    @(posedge clk); #1;
    length_min = 16'd4; length_max = 16'd0;
    clear_mon();
    fd = '{8'h21, 8'h22, 8'h23, 8'h24};
    send_frame(fd, 1'b1);
    wait_done(4, "min_edge");
    checks++;
    if (out_d.size() !== 4 || out_l[3] !== 1'b1 || out_u[3] !== 1'b1 ||
        st_q.size() !== 1 || st_q[0] !== {1'b0, 1'b0, 16'd4, 16'd4}) begin
      errors++;
      $display("FAIL min_edge: got beats=%0d status_n=%0d want 4 beats, pad=0 len=4 orig=4",
               out_d.size(), st_q.size());
    end
    // Exactly max beats ending in tlast: no truncation, input tuser kept.
    @(posedge clk); #1;
    length_min = 16'd0; length_max = 16'd4;
    clear_mon();
    fd = '{8'h31, 8'h32, 8'h33, 8'h34};
    send_frame(fd, 1'b0);
    wait_done(4, "max_edge");
    checks++;
    if (out_d.size() !== 4 || out_l[3] !== 1'b1 || out_u[3] !== 1'b0 || out_d[3] !== 8'h34 ||
        st_q.size() !== 1 || st_q[0] !== {1'b0, 1'b0, 16'd4, 16'd4}) begin
      errors++;
      $display("FAIL max_edge: got beats=%0d status_n=%0d want 4 beats u4=0, trunc=0 len=4 orig=4",
               out_d.size(), st_q.size());
    end
    // min > max: padding target clamps to max.
    @(posedge clk); #1;
    length_min = 16'd6; length_max = 16'd3;
    clear_mon();
    fd    = '{8'hD1, 8'hD2};
    exp_d = '{8'hD1, 8'hD2, 8'h00};
    send_frame(fd, 1'b1);
    wait_done(3, "clamp");
    checks++;
    if (out_d.size() !== 3 || st_q.size() !== 1 || st_q[0] !== {1'b1, 1'b0, 16'd3, 16'd2}) begin
      errors++;
      $display("FAIL clamp_status: got beats=%0d status_n=%0d want 3 beats, pad=1 len=3 orig=2",
               out_d.size(), st_q.size());
    end
    for (int i = 0; i < 3 && i < out_d.size(); i++) begin
      checks++;
      if (out_d[i] !== exp_d[i] || out_l[i] !== (i == 2) || out_u[i] !== (i == 2)) begin
        errors++;
        $display("FAIL clamp_beat[%0d]: got d=%h l=%b u=%b want d=%h l=%b u=%b",
                 i, out_d[i], out_l[i], out_u[i], exp_d[i], (i == 2), (i == 2));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] fd[$];
    logic [7:0] exp_d[$];
    @(posedge clk); #1;
    length_min = 16'd10; length_max = 16'd0;
    clear_mon();
    bp_en = 1'b1;
    fd    = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
    exp_d = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(fd, 1'b1);
    wait_done(10, "bp");
    bp_en = 1'b0;
    checks++;
    if (out_d.size() !== 10) begin
      errors++; $display("FAIL bp_count: got %0d want 10", out_d.size());
    end
    for (int i = 0; i < 10 && i < out_d.size(); i++) begin
      checks++;
      if (out_d[i] !== exp_d[i] || out_l[i] !== (i == 9) || out_u[i] !== (i == 9)) begin
        errors++;
        $display("FAIL bp_beat[%0d]: got d=%h l=%b u=%b want d=%h l=%b u=%b",
                 i, out_d[i], out_l[i], out_u[i], exp_d[i], (i == 9), (i == 9));
      end
    end
    checks++;
    if (stall_err !== 0) begin
      errors++; $display("FAIL bp_stall_stable: got %0d changes while stalled want 0", stall_err);
    end
    checks++;
    if (st_q.size() !== 1 || st_q[0] !== {1'b1, 1'b0, 16'd10, 16'd4}) begin
      errors++;
      $display("FAIL bp_status: got n=%0d want n=1 pad=1 len=10 orig=4", st_q.size());
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] fd[$];
    int n_st;
    @(posedge clk); #1;
    length_min = 16'd8; length_max = 16'd0;
    clear_mon();
    fd = '{8'hA1, 8'hA2, 8'hA3};
    send_frame(fd, 1'b1);
    @(posedge clk);
    @(posedge clk); #2;
    checks++;
    if (m_axis_tvalid !== 1'b1 || s_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL rst_pre_pad: got valid=%b ready=%b want valid=1 ready=0",
               m_axis_tvalid, s_axis_tready);
    end
    n_st = st_q.size();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, s_axis_tready, status_valid} !== 13'd0) begin
      errors++;
      $display("FAIL rst_async: got v=%b d=%h l=%b u=%b rdy=%b sv=%b want all 0",
               m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, s_axis_tready, status_valid);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (st_q.size() !== n_st || n_st !== 0) begin
      errors++; $display("FAIL rst_no_status: got %0d pulses want 0", st_q.size());
    end
    @(posedge clk); #1;
    length_min = 16'd0;
    clear_mon();
    fd = '{8'hC1, 8'hC2};
    send_frame(fd, 1'b0);
    wait_done(2, "post_rst");
    checks++;
    if (out_d.size() !== 2 || out_d[0] !== 8'hC1 || out_d[1] !== 8'hC2 ||
        out_l[0] !== 1'b0 || out_l[1] !== 1'b1) begin
      errors++;
      $display("FAIL post_rst_beats: got n=%0d want C1,C2 with tlast on beat 2", out_d.size());
    end
    checks++;
    if (st_q.size() !== 1 || st_q[0] !== {1'b0, 1'b0, 16'd2, 16'd2}) begin
      errors++;
      $display("FAIL post_rst_status: got n=%0d want n=1 pad=0 trunc=0 len=2 orig=2", st_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_padding();
    test_truncation();
    test_boundaries();
    test_backpressure();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
